// File: rtl/fb_pkg.sv
// ----------------------------------------------------------------------------
// fb_pkg : shared types and default geometry for the scrolling frame buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } fsm_state_t;

  localparam int         FB_H_RES       = 640;
  localparam int         FB_V_RES       = 480;
  localparam int         FB_PIX_W       = 5;
  localparam int         FB_STEP_W      = 4;
  localparam logic [4:0] FB_TRANSPARENT = 5'h16;

endpackage

`default_nettype wire

// File: rtl/fb_dual_port_ram.sv
// ----------------------------------------------------------------------------
// fb_dual_port_ram : one read port plus one read/write port, synchronous read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fb_dual_port_ram #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    i_a_addr,
  output logic [WIDTH-1:0] o_a_data,
  input  logic [AW-1:0]    i_b_addr,
  input  logic             i_b_we,
  input  logic [WIDTH-1:0] i_b_wdata,
  output logic [WIDTH-1:0] o_b_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_b_we) begin
      r_mem[i_b_addr] <= i_b_wdata;
    end
  end

  // Reads sample the array before this edge's write lands, so a collision returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_a_data  <= '0;
      o_b_rdata <= '0;
    end else begin
      o_a_data  <= r_mem[i_a_addr];
      o_b_rdata <= r_mem[i_b_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/scroll_frame_buffer.sv
// ----------------------------------------------------------------------------
// scroll_frame_buffer : two-page frame store with horizontal scroll and RMW writes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scroll_frame_buffer
  import fb_pkg::*;
#(
  parameter int               H_RES       = FB_H_RES,
  parameter int               V_RES       = FB_V_RES,
  parameter int               PIX_W       = FB_PIX_W,
  parameter logic [PIX_W-1:0] TRANSPARENT = PIX_W'(FB_TRANSPARENT),
  parameter int               STEP_W      = FB_STEP_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frameTick,
  input  logic              blank,
  input  logic              ScrollEnable,
  input  logic [STEP_W-1:0] scrollStep,
  input  logic              swapReq,
  input  logic [9:0]        writeX,
  input  logic [9:0]        writeY,
  input  logic [PIX_W-1:0]  pixelIn,
  input  logic              pixelValid,
  output logic              pixelReady,
  output logic [PIX_W-1:0]  pixelOut,
  output logic              SRAM_Read,
  output logic              displayPage
);

  localparam int PAGE_WORDS = H_RES * V_RES;
  localparam int DEPTH      = 2 * PAGE_WORDS;
  localparam int AW         = $clog2(DEPTH);
  localparam int SX_W       = $clog2(H_RES);

  localparam logic [AW-1:0] c_page_words = AW'(PAGE_WORDS);
  localparam logic [AW-1:0] c_h_res_a    = AW'(H_RES);
  localparam logic [10:0]   c_h_lim      = 11'(H_RES);
  localparam logic [10:0]   c_v_lim      = 11'(V_RES);
  localparam logic [SX_W:0] c_h_wrap     = (SX_W + 1)'(H_RES);

  fsm_state_t       r_state;
  logic [SX_W-1:0]  r_scroll_x;
  logic             r_page;
  logic             r_live;
  logic [AW-1:0]    r_wr_addr;
  logic [PIX_W-1:0] r_wr_pix;
  logic             r_wr_drop;

  logic [SX_W:0]    w_scroll_sum;
  logic [SX_W-1:0]  w_scroll_next;
  logic [10:0]      w_col_sum;
  logic [10:0]      w_col;
  logic             w_disp_in;
  logic [AW-1:0]    w_disp_base;
  logic [AW-1:0]    w_disp_addr;
  logic             w_wr_in;
  logic [AW-1:0]    w_back_base;
  logic [AW-1:0]    w_wr_addr;
  logic             w_accept;
  logic             w_b_we;
  logic [PIX_W-1:0] w_b_wdata;
  logic [PIX_W-1:0] w_b_rdata;

  // Step is far below H_RES, so one conditional subtract is a full modulo.
  assign w_scroll_sum  = {1'b0, r_scroll_x} + (SX_W + 1)'(scrollStep);
  assign w_scroll_next = (w_scroll_sum >= c_h_wrap) ? SX_W'(w_scroll_sum - c_h_wrap)
                                                    : SX_W'(w_scroll_sum);

  assign w_col_sum   = 11'(DrawX) + 11'(r_scroll_x);
  assign w_col       = (w_col_sum >= c_h_lim) ? (w_col_sum - c_h_lim) : w_col_sum;
  assign w_disp_in   = ({1'b0, DrawX} < c_h_lim) && ({1'b0, DrawY} < c_v_lim);
  assign w_disp_base = r_page ? c_page_words : '0;
  // Off-screen scan positions read the page origin so the address never leaves the array.
  assign w_disp_addr = w_disp_in ? (w_disp_base + AW'(DrawY) * c_h_res_a + AW'(w_col))
                                 : w_disp_base;

  assign w_wr_in     = ({1'b0, writeX} < c_h_lim) && ({1'b0, writeY} < c_v_lim);
  assign w_back_base = r_page ? '0 : c_page_words;
  assign w_wr_addr   = w_wr_in ? (w_back_base + AW'(writeY) * c_h_res_a + AW'(writeX)) : '0;

  assign w_accept    = (r_state == ST_IDLE) && blank && pixelValid && r_live;
  assign pixelReady  = w_accept;
  assign SRAM_Read   = (r_state == ST_IDLE);
  assign displayPage = r_page;

  // Write enable decodes the async-reset state, so reset kills a pending write before the edge.
  assign w_b_we    = (r_state == ST_WRITE) && !r_wr_drop;
  assign w_b_wdata = (r_wr_pix == TRANSPARENT) ? w_b_rdata : r_wr_pix;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_scroll_x <= '0;
      r_page     <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (frameTick) begin
        if (ScrollEnable) r_scroll_x <= w_scroll_next;
        if (swapReq)      r_page     <= ~r_page;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_wr_addr <= '0;
      r_wr_pix  <= '0;
      r_wr_drop <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wr_addr <= w_wr_addr;
            r_wr_pix  <= pixelIn;
            r_wr_drop <= !w_wr_in;
            r_state   <= ST_READ;
          end
        end
        ST_READ:  r_state <= ST_WRITE;
        ST_WRITE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  fb_dual_port_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_ram (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_a_addr  (w_disp_addr),
    .o_a_data  (pixelOut),
    .i_b_addr  (r_wr_addr),
    .i_b_we    (w_b_we),
    .i_b_wdata (w_b_wdata),
    .o_b_rdata (w_b_rdata)
  );

endmodule

`default_nettype wire
